// File: rtl/adder_stim_gen.sv
// adder_stim_gen: operand-stimulus generator for adder benches.
// Drives WIDTH-bit operands A/B under a valid/en handshake. Four sequence
// modes are available: count, LFSR, corner list and walking-one. A run can
// be bounded by NUM_VEC vectors or left free-running (NUM_VEC = 0).
// Reset is asynchronous and active-low on port rst.
// Optional macro ADDER_STIM_NEGEDGE_LAUNCH_EN re-launches A/B/valid on the
// falling clock edge so the consumer sees operands settle mid-cycle.
module adder_stim_gen #(
    parameter int                 WIDTH     = 4,
    parameter int                 NUM_VEC   = 0,
    parameter logic [2*WIDTH-1:0] LFSR_SEED = {{(2*WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             valid,
    output logic             done,
    output logic [31:0]      vec_cnt
);

    localparam int SW = 2 * WIDTH;

    localparam logic [WIDTH-1:0] OP_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] OP_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // A zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [SW-1:0] SEED_EFF = (LFSR_SEED == {SW{1'b0}}) ?
                                         {{(SW-1){1'b0}}, 1'b1} : LFSR_SEED;

    // Count value held while the final vector of a bounded run is presented.
    localparam logic [31:0] LAST_CNT = 32'(NUM_VEC - 1);
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [31:0]     cnt_q, cnt_d;

    logic            lfsr_fb_s;
    logic [WIDTH-1:0] walk_a_s;
    logic [SW-1:0]   s_nxt_s;
    logic [2:0]      idx_nxt_s;
    logic            accept_s;
    logic            is_last_s;

    // Corner-case list entry {A,B} for a given list index.
    function automatic logic [SW-1:0] corner_vec(input logic [2:0] idx);
        logic [SW-1:0] v;
        case (idx)
            3'd0:    v = {OP_ZERO, OP_ZERO};
            3'd1:    v = {OP_ONES, OP_ZERO};
            3'd2:    v = {OP_ZERO, OP_ONES};
            3'd3:    v = {OP_ONES, OP_ONES};
            3'd4:    v = {OP_ONES, OP_ONE};
            3'd5:    v = {OP_ONE,  OP_ONES};
            default: v = {OP_ZERO, OP_ZERO};
        endcase
        return v;
    endfunction

    // First vector of a run for the mode being latched.
    function automatic logic [SW-1:0] first_vec(input logic [1:0] m);
        logic [SW-1:0] v;
        case (m)
            2'd0:    v = {SW{1'b0}};
            2'd1:    v = SEED_EFF;
            2'd2:    v = corner_vec(3'd0);
            2'd3:    v = {OP_ONE, ~OP_ONE};
            default: v = {SW{1'b0}};
        endcase
        return v;
    endfunction

    // Maximal-length feedback taps, selected by sequence-state width.
    generate
        if (SW == 4) begin : g_fb4
            assign lfsr_fb_s = s_q[3] ^ s_q[2];
        end else if (SW == 8) begin : g_fb8
            assign lfsr_fb_s = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];
        end else if (SW == 16) begin : g_fb16
            assign lfsr_fb_s = s_q[15] ^ s_q[14] ^ s_q[12] ^ s_q[3];
        end else begin : g_fb32
            assign lfsr_fb_s = s_q[SW-1] ^ s_q[21] ^ s_q[1] ^ s_q[0];
        end
    endgenerate

    // Walking-one: rotate the single set bit of A one place left.
    assign walk_a_s = {s_q[SW-2:WIDTH], s_q[SW-1]};

    assign accept_s  = valid_q & en;
    assign is_last_s = (NUM_VEC != 0) && (cnt_q == LAST_CNT);

    // Next vector of the active sequence, used on every non-final acceptance.
    always_comb begin
        s_nxt_s   = s_q;
        idx_nxt_s = idx_q;
        case (mode_q)
            2'd0: begin
                s_nxt_s = s_q + {{(SW-1){1'b0}}, 1'b1};
            end
            2'd1: begin
                s_nxt_s = {s_q[SW-2:0], lfsr_fb_s};
            end
            2'd2: begin
                idx_nxt_s = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                s_nxt_s   = corner_vec(idx_nxt_s);
            end
            2'd3: begin
                s_nxt_s = {walk_a_s, ~walk_a_s};
            end
            default: begin
                s_nxt_s   = s_q;
                idx_nxt_s = idx_q;
            end
        endcase
    end

    // Run control: start handling, handshake acceptance and run completion.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        s_d     = s_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    s_d     = first_vec(mode);
                    idx_d   = 3'd0;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at while a run is active.
                if (accept_s) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
                    if (is_last_s) begin
                        // Final vector stays on A/B after the run ends.
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        s_d   = s_nxt_s;
                        idx_d = idx_nxt_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Posedge state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            s_q     <= {SW{1'b0}};
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done    = done_q;
    assign vec_cnt = cnt_q;

`ifdef ADDER_STIM_NEGEDGE_LAUNCH_EN
    logic [WIDTH-1:0] a_n_q;
    logic [WIDTH-1:0] b_n_q;
    logic             valid_n_q;

    // Falling-edge relaunch so operands are settled well before the posedge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            a_n_q     <= {WIDTH{1'b0}};
            b_n_q     <= {WIDTH{1'b0}};
            valid_n_q <= 1'b0;
        end else begin
            a_n_q     <= s_q[SW-1:WIDTH];
            b_n_q     <= s_q[WIDTH-1:0];
            valid_n_q <= valid_q;
        end
    end

    assign A     = a_n_q;
    assign B     = b_n_q;
    assign valid = valid_n_q;
`else
    assign A     = s_q[SW-1:WIDTH];
    assign B     = s_q[WIDTH-1:0];
    assign valid = valid_q;
`endif

endmodule

// File: tb/tb_adder_stim_gen.sv
// tb_adder_stim_gen: directed bench for adder_stim_gen (WIDTH=4).
// Three instances share the inputs: NUM_VEC=3, NUM_VEC=0 (free-run) and
// NUM_VEC=7. Inputs change and outputs are sampled 1 time unit after the
// falling clock edge, which is stable for both output launch options.
module tb_adder_stim_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       en;

    logic [3:0]  a3, b3, a0, b0, a7, b7;
    logic        v3, v0, v7, d3, d0, d7;
    logic [31:0] c3, c0, c7;

    int n_cmp;
    int n_err;

    logic [7:0] corner_exp [0:6];
    logic [7:0] walk_exp   [0:4];
    logic [7:0] lfsr_exp   [0:4];

    adder_stim_gen #(.WIDTH(4), .NUM_VEC(3), .LFSR_SEED(8'h01)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .en(en),
        .A(a3), .B(b3), .valid(v3), .done(d3), .vec_cnt(c3)
    );

    adder_stim_gen #(.WIDTH(4), .NUM_VEC(0), .LFSR_SEED(8'h01)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .en(en),
        .A(a0), .B(b0), .valid(v0), .done(d0), .vec_cnt(c0)
    );

    adder_stim_gen #(.WIDTH(4), .NUM_VEC(7), .LFSR_SEED(8'h01)) u_dut7 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .en(en),
        .A(a7), .B(b7), .valid(v7), .done(d7), .vec_cnt(c7)
    );

    // Free-running bench clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        cyc();
    endtask

    task automatic do_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        corner_exp[0] = 8'h00; corner_exp[1] = 8'hF0; corner_exp[2] = 8'h0F;
        corner_exp[3] = 8'hFF; corner_exp[4] = 8'hF1; corner_exp[5] = 8'h1F;
        corner_exp[6] = 8'h00;
        walk_exp[0] = 8'h1E; walk_exp[1] = 8'h2D; walk_exp[2] = 8'h4B;
        walk_exp[3] = 8'h87; walk_exp[4] = 8'h1E;
        lfsr_exp[0] = 8'h01; lfsr_exp[1] = 8'h02; lfsr_exp[2] = 8'h04;
        lfsr_exp[3] = 8'h08; lfsr_exp[4] = 8'h11;

        rst   = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        en    = 1'b0;
        #1;
        chk_val("rst_ab",    32'({a0, b0}), 32'h00);
        chk_val("rst_valid", 32'(v0), 32'd0);
        chk_val("rst_done",  32'(d0), 32'd0);
        chk_val("rst_cnt",   c0, 32'd0);
        cyc();
        rst = 1'b1;
        repeat (2) cyc();
        chk_val("idle_valid", 32'(v0), 32'd0);

        // Bounded count run, then a re-run from DONE in walking-one mode.
        en = 1'b1;
        do_start(2'd0);
        chk_val("cnt3_first_valid", 32'(v3), 32'd1);
        chk_val("cnt3_first_cnt",   c3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk_val("cnt3_vec", 32'({a3, b3}), 32'(i));
            cyc();
        end
        chk_val("cnt3_done",  32'(d3), 32'd1);
        chk_val("cnt3_valid", 32'(v3), 32'd0);
        chk_val("cnt3_cnt",   c3, 32'd3);
        chk_val("cnt3_hold",  32'({a3, b3}), 32'h02);
        do_start(2'd3);
        chk_val("rerun_done", 32'(d3), 32'd0);
        chk_val("rerun_cnt",  c3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk_val("rerun_walk", 32'({a3, b3}), 32'(walk_exp[i]));
            cyc();
        end
        chk_val("rerun_done2", 32'(d3), 32'd1);
        chk_val("rerun_hold",  32'({a3, b3}), 32'h4B);

        // Free-run count: stall, start-during-run, wrap, mid-cycle reset.
        rst_pulse();
        do_start(2'd0);
        repeat (53) cyc();
        chk_val("cnt_35", 32'({a0, b0}), 32'h35);
        chk_val("cnt_35_cnt", c0, 32'd53);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_val("stall_ab",    32'({a0, b0}), 32'h35);
            chk_val("stall_valid", 32'(v0), 32'd1);
            chk_val("stall_cnt",   c0, 32'd53);
        end
        en    = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_val("start_in_run_ab",  32'({a0, b0}), 32'h36);
        chk_val("start_in_run_cnt", c0, 32'd54);
        repeat (202) cyc();
        chk_val("wrap_ab",   32'({a0, b0}), 32'h00);
        chk_val("wrap_cnt",  c0, 32'd256);
        chk_val("wrap_done", 32'(d0), 32'd0);
        repeat (53) cyc();
        chk_val("pre_rst_ab", 32'({a0, b0}), 32'h35);
        #2;
        rst = 1'b0;
        #1;
        chk_val("async_rst_ab",    32'({a0, b0}), 32'h00);
        chk_val("async_rst_valid", 32'(v0), 32'd0);
        chk_val("async_rst_done",  32'(d0), 32'd0);
        chk_val("async_rst_cnt",   c0, 32'd0);
        #2;
        rst = 1'b1;
        repeat (3) cyc();
        chk_val("post_rst_valid", 32'(v0), 32'd0);
        chk_val("post_rst_cnt",   c0, 32'd0);

        // LFSR: first vectors, then period 255 despite a mode change mid-run.
        do_start(2'd1);
        for (int i = 0; i < 5; i++) begin
            chk_val("lfsr_vec", 32'({a0, b0}), 32'(lfsr_exp[i]));
            if (i < 4) cyc();
        end
        mode = 2'd2;
        repeat (251) cyc();
        chk_val("lfsr_period",     32'({a0, b0}), 32'h01);
        chk_val("lfsr_period_cnt", c0, 32'd255);

        // Corner list with index wrap, bounded at 7 vectors.
        rst_pulse();
        do_start(2'd2);
        for (int i = 0; i < 7; i++) begin
            chk_val("corner_vec",   32'({a7, b7}), 32'(corner_exp[i]));
            chk_val("corner_valid", 32'(v7), 32'd1);
            cyc();
        end
        chk_val("corner_done",  32'(d7), 32'd1);
        chk_val("corner_valid_end", 32'(v7), 32'd0);
        chk_val("corner_cnt",   c7, 32'd7);
        chk_val("corner_hold",  32'({a7, b7}), 32'h00);

        // Walking-one wrap on the free-running instance.
        rst_pulse();
        do_start(2'd3);
        for (int i = 0; i < 5; i++) begin
            chk_val("walk_vec", 32'({a0, b0}), 32'(walk_exp[i]));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
